// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential fetch with req/ack handshake, prefetch FIFO and redirect flush.
// Optional performance counters (fetch_count, flush_count) are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   mem_instr [DEPTH];
    logic [ADDR_W-1:0]   mem_pc    [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_after;
    logic [DATA_W-1:0]   last_instr;
    logic [ADDR_W-1:0]   last_pc;
    logic                push;
    logic                pop;

    // A redirect cancels both the push and the pop of its cycle.
    assign push        = (state == REQ) && imem_ack && !redirect_valid;
    assign pop         = (count != '0) && instr_ready && !redirect_valid;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem_instr[rd_ptr] : last_instr;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : last_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if ((count < CNT_W'(DEPTH)) && !redirect_valid) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    next_state = (!redirect_valid && (count_after < CNT_W'(DEPTH))) ? REQ : IDLE;
                end else if (redirect_valid) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // While flushing, the abandoned request keeps its original address until acked.
    always_comb begin
        imem_req  = (state == REQ) || (state == FLUSH);
        imem_addr = (state == FLUSH) ? hold_addr : pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= ADDR_W'(RESET_PC);
            hold_addr  <= ADDR_W'(RESET_PC);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc & ~ADDR_W'(1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if ((state == REQ) && !imem_ack) begin
                hold_addr <= pc;
            end
        end else begin
            if (push) begin
                pc     <= pc + ADDR_W'(2);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                last_instr <= mem_instr[rd_ptr];
                last_pc    <= mem_pc[rd_ptr];
            end
            count <= count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect_valid) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, full FIFO, slow memory, redirects, PC wrap, async reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int tests  = 0;
    int failed = 0;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory contents as a function of address.
    function automatic logic [15:0] w(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic step();
        @(negedge clk);
        imem_rdata = w(imem_addr);
    endtask

    task automatic do_reset(input logic ack, input logic ready);
        rst            = 1'b1;
        imem_ack       = ack;
        instr_ready    = ready;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_rdata     = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0; imem_rdata = 16'h0;
        step();
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_req got %0b want 0", imem_req); end
        tests++; if (imem_addr !== 16'h0) begin failed++; $display("FAIL reset_addr got %h want 0000", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        tests++; if (instr !== 16'h0) begin failed++; $display("FAIL reset_instr got %h want 0000", instr); end
        tests++; if (instr_pc !== 16'h0) begin failed++; $display("FAIL reset_pc got %h want 0000", instr_pc); end
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL stream_req[%0d] got %0b want 1", i, imem_req); end
            tests++; if (imem_addr !== 16'(2*i)) begin failed++; $display("FAIL stream_addr[%0d] got %h want %h", i, imem_addr, 16'(2*i)); end
            if (i == 0) begin
                tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL stream_valid0 got %0b want 0", instr_valid); end
            end else begin
                tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL stream_valid[%0d] got %0b want 1", i, instr_valid); end
                tests++; if (instr_pc !== 16'(2*(i-1))) begin failed++; $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, 16'(2*(i-1))); end
                tests++; if (instr !== w(16'(2*(i-1)))) begin failed++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr, w(16'(2*(i-1)))); end
            end
        end
    endtask

    task automatic test_full();
        int pushes = 0;
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (imem_req && imem_ack) pushes++;
        end
        tests++; if (pushes !== 4) begin failed++; $display("FAIL full_pushes got %0d want 4", pushes); end
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL full_req got %0b want 0", imem_req); end
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL full_valid got %0b want 1", instr_valid); end
        tests++; if (instr_pc !== 16'h0) begin failed++; $display("FAIL full_head_pc got %h want 0000", instr_pc); end
        tests++; if (imem_addr !== 16'h8) begin failed++; $display("FAIL full_addr got %h want 0008", imem_addr); end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL drain_valid[%0d] got %0b want 1", k, instr_valid); end
            tests++; if (instr_pc !== 16'(2*k)) begin failed++; $display("FAIL drain_pc[%0d] got %h want %h", k, instr_pc, 16'(2*k)); end
            tests++; if (instr !== w(16'(2*k))) begin failed++; $display("FAIL drain_instr[%0d] got %h want %h", k, instr, w(16'(2*k))); end
            if (k == 2) begin
                tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL resume_req got %0b want 1", imem_req); end
                tests++; if (imem_addr !== 16'h8) begin failed++; $display("FAIL resume_addr got %h want 0008", imem_addr); end
            end
        end
    endtask

    task automatic test_delayed_ack();
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL wait_req[%0d] got %0b want 1", i, imem_req); end
            tests++; if (imem_addr !== 16'h0) begin failed++; $display("FAIL wait_addr[%0d] got %h want 0000", i, imem_addr); end
            tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL wait_valid[%0d] got %0b want 0", i, instr_valid); end
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL slow_valid got %0b want 1", instr_valid); end
        tests++; if (instr_pc !== 16'h0) begin failed++; $display("FAIL slow_pc got %h want 0000", instr_pc); end
        tests++; if (instr !== w(16'h0)) begin failed++; $display("FAIL slow_instr got %h want %h", instr, w(16'h0)); end
        tests++; if (imem_addr !== 16'h2) begin failed++; $display("FAIL slow_next_addr got %h want 0002", imem_addr); end
    endtask

    task automatic test_redirect_pending();
        do_reset(1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect_valid = 1'b0;
        step();
        tests++; if (imem_addr !== 16'h0010 || imem_req !== 1'b1) begin failed++; $display("FAIL pend_start got req=%0b addr=%h want req=1 addr=0010", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) step();
            tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin failed++; $display("FAIL flush_hold[%0d] got req=%0b addr=%h want req=1 addr=0010", i, imem_req, imem_addr); end
            tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL flush_valid[%0d] got %0b want 0", i, instr_valid); end
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failed++; $display("FAIL flush_discard got req=%0b valid=%0b want 0 0", imem_req, instr_valid); end
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin failed++; $display("FAIL redir_req got req=%0b addr=%h want req=1 addr=0100", imem_req, imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL redir_valid_pre got %0b want 0", instr_valid); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin failed++; $display("FAIL redir_head got valid=%0b pc=%h want 1 0100", instr_valid, instr_pc); end
        tests++; if (instr !== w(16'h0100)) begin failed++; $display("FAIL redir_instr got %h want %h", instr, w(16'h0100)); end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step();
        tests++; if (imem_addr !== 16'h8 || instr_pc !== 16'h6) begin failed++; $display("FAIL rap_pre got addr=%h pc=%h want 0008 0006", imem_addr, instr_pc); end
        redirect_valid = 1'b1; redirect_pc = 16'h0041;
        step();
        redirect_valid = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rap_empty got %0b want 0", instr_valid); end
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rap_req got %0b want 0", imem_req); end
        tests++; if (instr_pc !== 16'h4 || instr !== w(16'h4)) begin failed++; $display("FAIL rap_hold got pc=%h instr=%h want 0004 %h", instr_pc, instr, w(16'h4)); end
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failed++; $display("FAIL rap_target got req=%0b addr=%h want 1 0040", imem_req, imem_addr); end
        step();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== w(16'h0040)) begin failed++; $display("FAIL rap_head got valid=%0b pc=%h instr=%h want 1 0040 %h", instr_valid, instr_pc, instr, w(16'h0040)); end
    endtask

    task automatic test_wrap();
        do_reset(1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin failed++; $display("FAIL wrap_addr0 got req=%0b addr=%h want 1 fffe", imem_req, imem_addr); end
        step();
        tests++; if (imem_addr !== 16'h0000) begin failed++; $display("FAIL wrap_addr1 got %h want 0000", imem_addr); end
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || instr !== w(16'hFFFE)) begin failed++; $display("FAIL wrap_head0 got valid=%0b pc=%h instr=%h want 1 fffe %h", instr_valid, instr_pc, instr, w(16'hFFFE)); end
        step();
        tests++; if (instr_pc !== 16'h0000 || instr !== w(16'h0000) || imem_addr !== 16'h0002) begin failed++; $display("FAIL wrap_head1 got pc=%h instr=%h addr=%h want 0000 %h 0002", instr_pc, instr, imem_addr, w(16'h0000)); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 16'h0020;
        step();
        redirect_valid = 1'b0;
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin failed++; $display("FAIL ar_pre got req=%0b addr=%h want 1 0020", imem_req, imem_addr); end
        #2 rst = 1'b1; imem_ack = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin failed++; $display("FAIL ar_now got req=%0b addr=%h want 0 0000", imem_req, imem_addr); end
        tests++; if (instr_valid !== 1'b0 || instr_pc !== 16'h0) begin failed++; $display("FAIL ar_out got valid=%0b pc=%h want 0 0000", instr_valid, instr_pc); end
        step();
        rst = 1'b0;
        step();
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL ar_late_ack got valid=%0b want 0", instr_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failed++; $display("FAIL ar_restart got req=%0b addr=%h want 1 0000", imem_req, imem_addr); end
        imem_ack = 1'b0;
        step();
        tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL ar_settle got valid=%0b want 0", instr_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_delayed_ack();
        test_redirect_pending();
        test_redirect_ack_pop();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
